// File: rtl/ddeglitch_xloop_xreg_xfreq_xu24.sv
// ddeglitch_xloop_xreg_xfreq_xu24
// Deglitcher for a raw asynchronous input: a 2-flop synchronizer feeds a
// four-state qualification FSM that drives a registered level output o.
// Optional feature macro DDEGLITCH_EDGE_FLAG_EN builds the rise/fall pulses
// and the saturating glitch counter; when it is undefined those outputs are
// tied low and their flops are not built.
//
// state  | meaning
// LOW    | o=0, waiting for s=1
// QUAL_H | s=1 seen, counting stable cycles toward HIGH
// HIGH   | o=1, waiting for s=0
// QUAL_L | s=0 seen, counting stable cycles toward LOW
//
// Timing: entry into QUAL_x counts as the first stable cycle (counter=1), and
// o toggles on the edge where the count reaches DEB_CYC, so a held input shows
// up on o 2+DEB_CYC edges after capture. With DEB_CYC=1 the toggle happens on
// the entry edge itself and the FSM leaves QUAL_x on the following edge.

module ddeglitch_xloop_xreg_xfreq_xu24 #(
  parameter int CNT_W   = 8,
  parameter int DEB_CYC = 16
) (
  input  logic       CELCLK,
  input  logic       CELRSTN,
  input  logic       CELV,
  input  logic       CELG,
  input  logic       SUB,
  input  logic       i,
  output logic       o,
  output logic       rise,
  output logic       fall,
  output logic [7:0] glitch_cnt
);

  typedef enum logic [1:0] {LOW, QUAL_H, HIGH, QUAL_L} state_t;

  localparam logic [CNT_W-1:0] DEB     = CNT_W'(DEB_CYC);
  localparam logic             DEB_ONE = (DEB_CYC == 1);

  logic             sync1;
  logic             s;
  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic [CNT_W-1:0] cnt_inc;
  logic             o_q;
  logic             o_nxt;
  logic             go_up;
  logic             go_dn;
  logic             abort;

  // Supply/substrate pins carry no logic function.
  logic unused_pwr;
  assign unused_pwr = CELV ^ CELG ^ SUB;

  assign cnt_inc = cnt + CNT_W'(1);

  // Two-flop synchronizer on the raw input.
  always_ff @(posedge CELCLK or negedge CELRSTN) begin
    if (!CELRSTN) begin
      sync1 <= 1'b0;
      s     <= 1'b0;
    end else begin
      sync1 <= i;
      s     <= sync1;
    end
  end

  // FSM state, qualification counter and output level registers.
  always_ff @(posedge CELCLK or negedge CELRSTN) begin
    if (!CELRSTN) begin
      state <= LOW;
      cnt   <= '0;
      o_q   <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      o_q   <= o_nxt;
    end
  end

  // Next-state, counter and toggle/abort decode.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    o_nxt     = o_q;
    go_up     = 1'b0;
    go_dn     = 1'b0;
    abort     = 1'b0;
    case (state)
      LOW: begin
        if (s) begin
          state_nxt = QUAL_H;
          cnt_nxt   = CNT_W'(1);
          if (DEB_ONE) begin
            o_nxt = 1'b1;
            go_up = 1'b1;
          end
        end
      end
      QUAL_H: begin
        if (DEB_ONE) begin
          state_nxt = HIGH;
          cnt_nxt   = '0;
        end else if (s) begin
          if (cnt_inc == DEB) begin
            state_nxt = HIGH;
            cnt_nxt   = '0;
            o_nxt     = 1'b1;
            go_up     = 1'b1;
          end else begin
            cnt_nxt = cnt_inc;
          end
        end else begin
          state_nxt = LOW;
          cnt_nxt   = '0;
          abort     = 1'b1;
        end
      end
      HIGH: begin
        if (!s) begin
          state_nxt = QUAL_L;
          cnt_nxt   = CNT_W'(1);
          if (DEB_ONE) begin
            o_nxt = 1'b0;
            go_dn = 1'b1;
          end
        end
      end
      QUAL_L: begin
        if (DEB_ONE) begin
          state_nxt = LOW;
          cnt_nxt   = '0;
        end else if (!s) begin
          if (cnt_inc == DEB) begin
            state_nxt = LOW;
            cnt_nxt   = '0;
            o_nxt     = 1'b0;
            go_dn     = 1'b1;
          end else begin
            cnt_nxt = cnt_inc;
          end
        end else begin
          state_nxt = HIGH;
          cnt_nxt   = '0;
          abort     = 1'b1;
        end
      end
      default: begin
        state_nxt = LOW;
        cnt_nxt   = '0;
        o_nxt     = 1'b0;
      end
    endcase
  end

  assign o = o_q;

`ifdef DDEGLITCH_EDGE_FLAG_EN
  logic       rise_q;
  logic       fall_q;
  logic [7:0] glitch_q;

  // Edge pulses registered alongside o; glitch counter saturates at 255.
  always_ff @(posedge CELCLK or negedge CELRSTN) begin
    if (!CELRSTN) begin
      rise_q   <= 1'b0;
      fall_q   <= 1'b0;
      glitch_q <= 8'd0;
    end else begin
      rise_q <= go_up;
      fall_q <= go_dn;
      if (abort && (glitch_q != 8'hFF)) begin
        glitch_q <= glitch_q + 8'd1;
      end
    end
  end

  assign rise       = rise_q;
  assign fall       = fall_q;
  assign glitch_cnt = glitch_q;
`else
  logic unused_flags;
  assign unused_flags = go_up ^ go_dn ^ abort;

  assign rise       = 1'b0;
  assign fall       = 1'b0;
  assign glitch_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_ddeglitch_xloop_xreg_xfreq_xu24.sv
// Bench for ddeglitch_xloop_xreg_xfreq_xu24: DEB_CYC=4 main instance plus a
// DEB_CYC=1 instance. Expected output edges are queued when the input is driven
// and popped when o changes. Flag expectations follow DDEGLITCH_EDGE_FLAG_EN.

module tb_ddeglitch_xloop_xreg_xfreq_xu24;

`ifdef DDEGLITCH_EDGE_FLAG_EN
  localparam logic FLAGS = 1'b1;
`else
  localparam logic FLAGS = 1'b0;
`endif

  typedef struct {
    int   cyc;
    logic o;
    logic rise;
    logic fall;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       i = 1'b0;
  logic       o, rise, fall;
  logic [7:0] glitch_cnt;
  logic       i1 = 1'b0;
  logic       o1, rise1, fall1;
  logic [7:0] glitch_cnt1;

  int   cyc = 0;
  int   total = 0;
  int   passed = 0;
  int   both_hi = 0;
  exp_t sb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if ((rise === 1'b1 && fall === 1'b1) || (rise1 === 1'b1 && fall1 === 1'b1)) both_hi <= both_hi + 1;

  ddeglitch_xloop_xreg_xfreq_xu24 #(.CNT_W(8), .DEB_CYC(4)) dut (
    .CELCLK(clk), .CELRSTN(rst_n), .CELV(1'b1), .CELG(1'b0), .SUB(1'b0),
    .i(i), .o(o), .rise(rise), .fall(fall), .glitch_cnt(glitch_cnt)
  );

  ddeglitch_xloop_xreg_xfreq_xu24 #(.CNT_W(8), .DEB_CYC(1)) dut1 (
    .CELCLK(clk), .CELRSTN(rst_n), .CELV(1'b1), .CELG(1'b0), .SUB(1'b0),
    .i(i1), .o(o1), .rise(rise1), .fall(fall1), .glitch_cnt(glitch_cnt1)
  );

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_o_change(input int budget, output int at, output bit ok,
                               output bit saw_rise, output bit saw_fall);
    logic prev;
    prev = o; ok = 1'b0; at = -1; saw_rise = 1'b0; saw_fall = 1'b0;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      if (o !== prev) begin
        ok = 1'b1;
        at = cyc;
        break;
      end
      if (rise === 1'b1) saw_rise = 1'b1;
      if (fall === 1'b1) saw_fall = 1'b1;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; i = 1'b0; i1 = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++; if (o !== 1'b0) $display("FAIL reset_o: got %b want 0", o); else passed++;
    total++; if (rise !== 1'b0) $display("FAIL reset_rise: got %b want 0", rise); else passed++;
    total++; if (fall !== 1'b0) $display("FAIL reset_fall: got %b want 0", fall); else passed++;
    total++; if (glitch_cnt !== 8'd0) $display("FAIL reset_glitch: got %0d want 0", glitch_cnt); else passed++;
    total++; if (o1 !== 1'b0) $display("FAIL reset_o1: got %b want 0", o1); else passed++;
    @(posedge clk); #1 rst_n = 1'b1;
    step(4);
  endtask

  task automatic test_rise();
    exp_t e; int at; bit ok, sr, sf;
    step(1);
    e.cyc = cyc + 6; e.o = 1'b1; e.rise = FLAGS; e.fall = 1'b0;
    i = 1'b1;
    sb.push_back(e);
    wait_o_change(20, at, ok, sr, sf);
    e = sb.pop_front();
    total++; if (!ok || at != e.cyc) $display("FAIL rise_latency: got cycle %0d want %0d", at, e.cyc); else passed++;
    total++; if (o !== e.o) $display("FAIL rise_o: got %b want %b", o, e.o); else passed++;
    total++; if (rise !== e.rise) $display("FAIL rise_pulse: got %b want %b", rise, e.rise); else passed++;
    total++; if (fall !== e.fall) $display("FAIL rise_nofall: got %b want %b", fall, e.fall); else passed++;
    total++; if (sr || sf) $display("FAIL rise_early_pulse: got rise=%b fall=%b want 0 0", sr, sf); else passed++;
    total++; if (glitch_cnt !== 8'd0) $display("FAIL rise_glitch: got %0d want 0", glitch_cnt); else passed++;
    @(negedge clk);
    total++; if (rise !== 1'b0) $display("FAIL rise_deassert: got %b want 0", rise); else passed++;
    total++; if (o !== 1'b1) $display("FAIL rise_hold: got %b want 1", o); else passed++;
    step(3);
  endtask

  task automatic test_fall();
    exp_t e; int at; bit ok, sr, sf;
    step(1);
    e.cyc = cyc + 6; e.o = 1'b0; e.rise = 1'b0; e.fall = FLAGS;
    i = 1'b0;
    sb.push_back(e);
    wait_o_change(20, at, ok, sr, sf);
    e = sb.pop_front();
    total++; if (!ok || at != e.cyc) $display("FAIL fall_latency: got cycle %0d want %0d", at, e.cyc); else passed++;
    total++; if (o !== e.o) $display("FAIL fall_o: got %b want %b", o, e.o); else passed++;
    total++; if (fall !== e.fall) $display("FAIL fall_pulse: got %b want %b", fall, e.fall); else passed++;
    total++; if (rise !== e.rise || sr) $display("FAIL fall_norise: got %b (earlier %b) want 0", rise, sr); else passed++;
    @(negedge clk);
    total++; if (fall !== 1'b0) $display("FAIL fall_deassert: got %b want 0", fall); else passed++;
    total++; if (rise !== 1'b0) $display("FAIL fall_norise_after: got %b want 0", rise); else passed++;
    step(3);
  endtask

  task automatic test_toggle();
    bit moved;
    moved = 1'b0;
    for (int k = 0; k < 20; k++) begin
      i = (k % 2 == 0);
      step(1);
      if (o !== 1'b0) moved = 1'b1;
    end
    i = 1'b0;
    for (int k = 0; k < 6; k++) begin
      step(1);
      if (o !== 1'b0) moved = 1'b1;
    end
    total++; if (moved) $display("FAIL toggle_o_moved: got o change want none"); else passed++;
    total++; if (glitch_cnt !== (FLAGS ? 8'd10 : 8'd0))
      $display("FAIL toggle_glitch: got %0d want %0d", glitch_cnt, (FLAGS ? 10 : 0)); else passed++;
  endtask

  task automatic test_reset_mid();
    exp_t e; int at; bit ok, sr, sf;
    step(1);
    i = 1'b1;
    step(5);
    rst_n = 1'b0;
    #1;
    total++; if (o !== 1'b0) $display("FAIL rstmid_o: got %b want 0", o); else passed++;
    total++; if (dut.cnt !== 8'd0) $display("FAIL rstmid_cnt: got %0d want 0", dut.cnt); else passed++;
    total++; if (glitch_cnt !== 8'd0) $display("FAIL rstmid_glitch: got %0d want 0", glitch_cnt); else passed++;
    total++; if (rise !== 1'b0) $display("FAIL rstmid_rise: got %b want 0", rise); else passed++;
    @(posedge clk); #1 rst_n = 1'b1;
    e.cyc = cyc + 6; e.o = 1'b1; e.rise = FLAGS; e.fall = 1'b0;
    sb.push_back(e);
    wait_o_change(20, at, ok, sr, sf);
    e = sb.pop_front();
    total++; if (!ok || at != e.cyc) $display("FAIL rstmid_latency: got cycle %0d want %0d", at, e.cyc); else passed++;
    total++; if (rise !== e.rise) $display("FAIL rstmid_rise_pulse: got %b want %b", rise, e.rise); else passed++;
    total++; if (glitch_cnt !== 8'd0) $display("FAIL rstmid_glitch_after: got %0d want 0", glitch_cnt); else passed++;
    step(3);
  endtask

  task automatic test_deb1();
    int at; bit ok; int c0;
    step(2);
    c0 = cyc; i1 = 1'b1; ok = 1'b0; at = -1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (o1 === 1'b1) begin ok = 1'b1; at = cyc; break; end
    end
    total++; if (!ok || at != c0 + 3) $display("FAIL deb1_rise_latency: got cycle %0d want %0d", at, c0 + 3); else passed++;
    total++; if (rise1 !== FLAGS) $display("FAIL deb1_rise_pulse: got %b want %b", rise1, FLAGS); else passed++;
    @(negedge clk);
    total++; if (rise1 !== 1'b0 || o1 !== 1'b1) $display("FAIL deb1_rise_after: got rise=%b o=%b want 0 1", rise1, o1); else passed++;
    step(2);
    c0 = cyc; i1 = 1'b0; ok = 1'b0; at = -1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (o1 === 1'b0) begin ok = 1'b1; at = cyc; break; end
    end
    total++; if (!ok || at != c0 + 3) $display("FAIL deb1_fall_latency: got cycle %0d want %0d", at, c0 + 3); else passed++;
    total++; if (fall1 !== FLAGS) $display("FAIL deb1_fall_pulse: got %b want %b", fall1, FLAGS); else passed++;
    total++; if (glitch_cnt1 !== 8'd0) $display("FAIL deb1_glitch: got %0d want 0", glitch_cnt1); else passed++;
    step(2);
  endtask

  task automatic test_glitch_sat();
    int g; bit bad_o; int bad_at; int bad_got; int bad_want; bit bad_g;
    i = 1'b0;
    step(12);
    g = 0; bad_o = 1'b0; bad_g = 1'b0; bad_at = -1; bad_got = 0; bad_want = 0;
    for (int n = 0; n < 300; n++) begin
      i = 1'b1;
      step(3);
      i = 1'b0;
      step(4);
      if (FLAGS && g < 255) g++;
      if (o !== 1'b0) bad_o = 1'b1;
      if (!bad_g && glitch_cnt !== 8'(g)) begin
        bad_g = 1'b1; bad_at = n; bad_got = int'(glitch_cnt); bad_want = g;
      end
      if (n == 0) begin
        total++; if (glitch_cnt !== (FLAGS ? 8'd1 : 8'd0))
          $display("FAIL glitch_first: got %0d want %0d", glitch_cnt, (FLAGS ? 1 : 0)); else passed++;
      end
    end
    total++; if (bad_g) $display("FAIL glitch_track: iter %0d got %0d want %0d", bad_at, bad_got, bad_want); else passed++;
    total++; if (bad_o) $display("FAIL glitch_o_moved: got o change want none"); else passed++;
    total++; if (glitch_cnt !== (FLAGS ? 8'd255 : 8'd0))
      $display("FAIL glitch_saturate: got %0d want %0d", glitch_cnt, (FLAGS ? 255 : 0)); else passed++;
    total++; if (both_hi != 0) $display("FAIL rise_fall_both: got %0d cycles want 0", both_hi); else passed++;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_rise();
    test_fall();
    test_toggle();
    test_reset_mid();
    test_deb1();
    test_glitch_sat();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/ddeglitch_xloop_xreg_xfreq_xu24.md
DDEGLITCH_XLOOP_XREG_XFREQ_XU24 -- requirements
Module: ddeglitch_XLOOP_XREG_XFREQ_XU24

Interface
REQ-001 Parameter CNT_W, default 8, width of the qualification counter.
REQ-002 Parameter DEB_CYC, default 16, consecutive stable cycles required before o follows i; legal range 1 .. 2^CNT_W-1.
REQ-003 Port CELCLK  input  1  block clock; all flops rise-edge triggered.
REQ-004 Port CELRSTN  input  1  reset, asynchronous assert, active-low; synchronous de-assert is the integrator's responsibility.
REQ-005 Port CELV  input  1  supply.
REQ-006 Port CELG  input  1  ground.
REQ-007 Port SUB  input  1  substrate.
REQ-008 Port i  input  1  raw asynchronous digital input (pad or comparator).
REQ-009 Port o  output  1  registered deglitched level; this port directly feeds the digital buffer brick's i pin.
REQ-010 Port rise  output  1  one-cycle pulse when o goes 0->1.
REQ-011 Port fall  output  1  one-cycle pulse when o goes 1->0.
REQ-012 Port glitch_cnt  output  8  saturating count of rejected glitches.

Function
REQ-013 i SHALL pass through a 2-flop synchronizer; s denotes the second flop output.
REQ-014 FSM SHALL have four states: LOW (o=0), QUAL_H, HIGH (o=1), QUAL_L.
REQ-015 LOW -> QUAL_H when s=1; HIGH -> QUAL_L when s=0; the counter loads 1 on entry.
REQ-016 In QUAL_x, when s still differs from o: increment the counter; when counter = DEB_CYC, go to the target state, toggle o and clear the counter on that edge.
REQ-017 In QUAL_x, when s equals o before the counter reaches DEB_CYC: return to the originating state, clear the counter and increment glitch_cnt.
REQ-018 With DEB_CYC=1, the FSM SHALL pass through QUAL_x for exactly one cycle; o toggles on the edge after s changes.
REQ-019 Latency: a change on i held stable SHALL appear on o exactly 2+DEB_CYC rising edges after the first edge that captures it.
REQ-020 rise/fall SHALL be registered, asserted in the same cycle o changes, and de-asserted the next cycle; they are never both high.
REQ-021 glitch_cnt SHALL saturate at 255 and never wrap.
REQ-022 The counter SHALL never exceed DEB_CYC; counter arithmetic is CNT_W bits unsigned.
REQ-023 If s toggles every cycle, o SHALL stay constant and glitch_cnt SHALL increment once per abort.

Reset
REQ-024 While CELRSTN=0: synchronizer flops=0, state=LOW, o=0, rise=0, fall=0, counter=0, glitch_cnt=0.
REQ-025 Reset asserted mid-qualification SHALL abort immediately without an o toggle or a glitch_cnt increment.
REQ-026 After reset release with i=1, o SHALL rise 2+DEB_CYC edges later and rise SHALL pulse; this is not counted as a glitch.

Configuration
REQ-027 Macro DDEGLITCH_EDGE_FLAG_EN defined: rise, fall and glitch_cnt behave per REQ-010..012, REQ-020, REQ-021.
REQ-028 Macro DDEGLITCH_EDGE_FLAG_EN undefined: rise, fall and glitch_cnt SHALL be tied to 0, their flops are not built, and o behaviour is unchanged.

Verification (DEB_CYC=4, macro defined unless stated)
REQ-029 Reset, then i 0->1 held -> o=1 and rise=1 on edge 6 after capture, rise=0 on edge 7, glitch_cnt=0.
REQ-030 i high for 3 cycles then low -> o stays 0, glitch_cnt=1; repeat 300 times -> glitch_cnt=255.
REQ-031 o=1, i 1->0 held -> o=0 and fall=1 on edge 6, with no rise pulse.
REQ-032 CELRSTN pulsed low in QUAL_H at counter=3 -> o=0, counter=0, glitch_cnt unchanged; with i still 1, o rises 6 edges after release.
REQ-033 DEB_CYC=1, i 0->1 -> o=1 on edge 3 after capture.
REQ-034 Macro undefined, same stimulus as REQ-029 and REQ-030 -> identical o timing; rise=fall=glitch_cnt=0 throughout.
